frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: walks header-linked point frames in a position RAM and streams points on step ticks.
// Optional FRAME_SEQUENCER_STATS_EN adds frameCount / missCount statistics outputs.
module frame_sequencer #(
    parameter int ADDR_W  = 13,
    parameter int POS_W   = 13,
    parameter int COLOR_W = 7,
    parameter int CNT_W   = 13,
    parameter int RD_LAT  = 2,
    parameter int DIV_W   = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [ADDR_W-1:0]          startAddr,
    input  logic                       step,
    input  logic [DIV_W-1:0]           divide,
    output logic [ADDR_W-1:0]          rdAddr,
    input  logic [3*POS_W+COLOR_W-1:0] rdData,
    output logic                       ptValid,
    input  logic                       ptReady,
    output logic [POS_W-1:0]           ptX,
    output logic [POS_W-1:0]           ptY,
    output logic [POS_W-1:0]           ptZ,
    output logic [COLOR_W-1:0]         ptColor,
    output logic                       frameEdge,
    output logic                       emptyFrame
`ifdef FRAME_SEQUENCER_STATS_EN
    ,
    output logic [15:0]                frameCount,
    output logic [15:0]                missCount
`endif
);
    localparam int DATA_W = 3*POS_W + COLOR_W;
    localparam logic [2:0] HDR_LAST = 3'(RD_LAT);
    localparam logic [2:0] PT_LAST  = 3'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, HDR_RD, PT_WAIT, PT_RD, PT_OUT, NEXT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, base_q, base_d, next_q, next_d;
    logic [CNT_W-1:0]    rpt_q, rpt_d, npts_q, npts_d, pt_cnt_q, pt_cnt_d, pass_q, pass_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [2:0]          lat_q, lat_d;
    logic                valid_q, valid_d, edge_q, edge_d, empty_q, empty_d;
    logic [POS_W-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    logic [COLOR_W-1:0]  color_q, color_d;

    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        base_d    = base_q;
        next_d    = next_q;
        rpt_d     = rpt_q;
        npts_d    = npts_q;
        pt_cnt_d  = pt_cnt_q;
        pass_d    = pass_q;
        div_d     = div_q;
        lat_d     = lat_q;
        valid_d   = valid_q;
        edge_d    = 1'b0;
        empty_d   = empty_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        color_d   = color_q;
        if (!enable) begin
            state_d   = IDLE;
            rd_addr_d = startAddr;
            valid_d   = 1'b0;
            div_d     = '0;
            lat_d     = '0;
            pt_cnt_d  = '0;
            pass_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_addr_d = startAddr;
                    div_d     = '0;
                    lat_d     = '0;
                    state_d   = HDR_RD;
                end
                // Header address changed on entry, so one extra edge is needed before rdData is valid.
                HDR_RD: begin
                    if (lat_q == HDR_LAST) begin
                        lat_d    = '0;
                        rpt_d    = rdData[CNT_W-1:0];
                        npts_d   = rdData[2*CNT_W-1:CNT_W];
                        next_d   = rdData[2*CNT_W+ADDR_W-1:2*CNT_W];
                        base_d   = rd_addr_q;
                        pt_cnt_d = '0;
                        pass_d   = '0;
                        if (rdData[2*CNT_W-1:CNT_W] == '0) begin
                            empty_d = 1'b1;
                            state_d = NEXT;
                        end else begin
                            rd_addr_d = rd_addr_q + 1'b1;
                            state_d   = PT_WAIT;
                        end
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                PT_WAIT: begin
                    if (step) begin
                        div_d = (div_q >= divide) ? '0 : div_q + 1'b1;
                        if (div_q == '0) begin
                            lat_d   = '0;
                            state_d = PT_RD;
                        end
                    end
                end
                // Point address has been stable since before the step, so RD_LAT edges suffice.
                PT_RD: begin
                    if (lat_q == PT_LAST) begin
                        color_d = rdData[DATA_W-1 -: COLOR_W];
                        x_d     = rdData[3*POS_W-1 -: POS_W];
                        y_d     = rdData[2*POS_W-1 -: POS_W];
                        z_d     = rdData[POS_W-1:0];
                        valid_d = 1'b1;
                        lat_d   = '0;
                        state_d = PT_OUT;
                    end else begin
                        lat_d = lat_q + 1'b1;
                    end
                end
                PT_OUT: begin
                    if (ptReady) begin
                        valid_d = 1'b0;
                        if (pt_cnt_q == npts_q - 1'b1) begin
                            edge_d   = 1'b1;
                            pt_cnt_d = '0;
                            if (pass_q < rpt_q) begin
                                pass_d    = pass_q + 1'b1;
                                rd_addr_d = base_q + 1'b1;
                                state_d   = PT_WAIT;
                            end else begin
                                pass_d  = '0;
                                state_d = NEXT;
                            end
                        end else begin
                            rd_addr_d = rd_addr_q + 1'b1;
                            pt_cnt_d  = pt_cnt_q + 1'b1;
                            state_d   = PT_WAIT;
                        end
                    end
                end
                NEXT: begin
                    rd_addr_d = next_q;
                    lat_d     = '0;
                    state_d   = HDR_RD;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef FRAME_SEQUENCER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        frame_cnt_d = edge_d ? frame_cnt_q + 1'b1 : frame_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (step && state_q != PT_WAIT && miss_cnt_q != '1)
            miss_cnt_d = miss_cnt_q + 1'b1;
    end

    assign frameCount = frame_cnt_q;
    assign missCount  = miss_cnt_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_addr_q <= '0;
            base_q    <= '0;
            next_q    <= '0;
            rpt_q     <= '0;
            npts_q    <= '0;
            pt_cnt_q  <= '0;
            pass_q    <= '0;
            div_q     <= '0;
            lat_q     <= '0;
            valid_q   <= 1'b0;
            edge_q    <= 1'b0;
            empty_q   <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            color_q   <= '0;
`ifdef FRAME_SEQUENCER_STATS_EN
            frame_cnt_q <= '0;
            miss_cnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            base_q    <= base_d;
            next_q    <= next_d;
            rpt_q     <= rpt_d;
            npts_q    <= npts_d;
            pt_cnt_q  <= pt_cnt_d;
            pass_q    <= pass_d;
            div_q     <= div_d;
            lat_q     <= lat_d;
            valid_q   <= valid_d;
            edge_q    <= edge_d;
            empty_q   <= empty_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            color_q   <= color_d;
`ifdef FRAME_SEQUENCER_STATS_EN
            frame_cnt_q <= frame_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
`endif
        end
    end

    assign rdAddr     = rd_addr_q;
    assign ptValid    = valid_q;
    assign ptX        = x_q;
    assign ptY        = y_q;
    assign ptZ        = z_q;
    assign ptColor    = color_q;
    assign frameEdge  = edge_q;
    assign emptyFrame = empty_q;
endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: RAM model, scoreboard of expected point addresses, table-driven frame runs.
module tb_frame_sequencer;
    logic        clk = 1'b0;
    logic        reset, enable, step, ptReady;
    logic [12:0] startAddr, rdAddr;
    logic [5:0]  divide;
    logic [45:0] rdData;
    logic        ptValid, frameEdge, emptyFrame;
    logic [12:0] ptX, ptY, ptZ;
    logic [6:0]  ptColor;
`ifdef FRAME_SEQUENCER_STATS_EN
    logic [15:0] frameCount, missCount;
`endif

    frame_sequencer #(.ADDR_W(13), .POS_W(13), .COLOR_W(7), .CNT_W(13), .RD_LAT(2), .DIV_W(6)) dut (
        .clk(clk), .reset(reset), .enable(enable), .startAddr(startAddr), .step(step),
        .divide(divide), .rdAddr(rdAddr), .rdData(rdData), .ptValid(ptValid), .ptReady(ptReady),
        .ptX(ptX), .ptY(ptY), .ptZ(ptZ), .ptColor(ptColor), .frameEdge(frameEdge),
        .emptyFrame(emptyFrame)
`ifdef FRAME_SEQUENCER_STATS_EN
        , .frameCount(frameCount), .missCount(missCount)
`endif
    );

    always #5 clk = ~clk;

    logic [45:0] mem [0:8191];
    logic [45:0] pipe1, pipe2;
    always @(posedge clk) begin
        pipe1 <= mem[rdAddr];
        pipe2 <= pipe1;
    end
    assign rdData = pipe2;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int acc_cnt = 0;
    int unsigned exp_q[$];

    function automatic logic [45:0] mk_pt(input logic [12:0] a);
        return {a[6:0], a, a ^ 13'h1555, ~a};
    endfunction

    function automatic logic [45:0] mk_hdr(input int r, input int n, input int nxt);
        logic [12:0] rr, nn, xx;
        rr = 13'(r);
        nn = 13'(n);
        xx = 13'(nxt);
        return {7'd0, xx, nn, rr};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted point must match the next expected RAM address.
    always @(negedge clk) begin
        if (frameEdge) edge_cnt++;
        if (ptValid && ptReady && !reset) begin
            acc_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_point: got %0h expected none", {ptColor, ptX, ptY, ptZ});
            end else begin
                logic [12:0] a;
                a = 13'(exp_q.pop_front());
                if ({ptColor, ptX, ptY, ptZ} !== mk_pt(a)) begin
                    errors++;
                    $display("FAIL point_data: got %0h expected %0h (addr %0d)",
                             {ptColor, ptX, ptY, ptZ}, mk_pt(a), a);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic init_mem();
        for (int a = 0; a < 8192; a++) mem[a] = mk_pt(13'(a));
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; step = 1'b0; ptReady = 1'b1;
        divide = '0; startAddr = '0;
        cycles(2);
        exp_q.delete();
        edge_cnt = 0;
        acc_cnt = 0;
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cycles(1);
        step = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!ptValid && n < 20) begin
            cycles(1);
            n++;
        end
        if (!ptValid) chk(name, 64'(ptValid), 64'd1);
    endtask

    typedef struct {
        int rpt; int npts; int div; int nsteps; int exp_pts; int exp_edges;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [45:0] snap;
        int stable, n, k;
        bit found;

        vecs[0] = '{1, 3, 0, 6, 6, 2};
        vecs[1] = '{0, 5, 2, 9, 3, 0};
        vecs[2] = '{0, 5, 1, 6, 3, 0};
        vecs[3] = '{2, 2, 3, 8, 2, 1};
        vecs[4] = '{0, 4, 0, 4, 4, 1};

        init_mem();
        do_reset();
        reset = 1'b1;
        cycles(1);
        chk("rst_rdAddr", 64'(rdAddr), 64'd0);
        chk("rst_ptValid", 64'(ptValid), 64'd0);
        chk("rst_fields", 64'({ptColor, ptX, ptY, ptZ}), 64'd0);
        chk("rst_frameEdge", 64'(frameEdge), 64'd0);
        chk("rst_emptyFrame", 64'(emptyFrame), 64'd0);
        reset = 1'b0;

        // Table-driven frame playback with self-looping header at address 0.
        foreach (vecs[v]) begin
            do_reset();
            init_mem();
            mem[0] = mk_hdr(vecs[v].rpt, vecs[v].npts, 0);
            divide = 6'(vecs[v].div);
            enable = 1'b1;
            cycles(10);
            k = 0;
            for (int i = 0; i < vecs[v].nsteps; i++) begin
                if (i % (vecs[v].div + 1) == 0) begin
                    exp_q.push_back(1 + (k % vecs[v].npts));
                    k++;
                end
                pulse_step();
                cycles(12);
            end
            chk($sformatf("vec%0d_points", v), 64'(acc_cnt), 64'(vecs[v].exp_pts));
            chk($sformatf("vec%0d_edges", v), 64'(edge_cnt), 64'(vecs[v].exp_edges));
            chk($sformatf("vec%0d_queue_left", v), 64'(exp_q.size()), 64'd0);
        end

        // Step-to-ptValid latency.
        do_reset();
        init_mem();
        mem[0] = mk_hdr(1, 3, 0);
        enable = 1'b1;
        cycles(10);
        exp_q.push_back(1);
        step = 1'b1;
        n = 0;
        while (n < 20) begin
            cycles(1);
            n++;
            step = 1'b0;
            if (ptValid) break;
        end
        chk("latency", 64'(n), 64'd3);
        cycles(10);
        chk("latency_queue_left", 64'(exp_q.size()), 64'd0);

        // Stall: ptReady low holds point stable, step during stall is dropped.
        do_reset();
        init_mem();
        mem[0] = mk_hdr(0, 3, 0);
        enable = 1'b1;
        cycles(10);
        ptReady = 1'b0;
        exp_q.push_back(1);
        pulse_step();
        wait_valid("stall_valid_timeout");
        snap = {ptColor, ptX, ptY, ptZ};
        stable = 0;
        for (int c = 0; c < 5; c++) begin
            step = (c == 1);
            cycles(1);
            if (ptValid && {ptColor, ptX, ptY, ptZ} == snap) stable++;
        end
        step = 1'b0;
        chk("stall_stable_cycles", 64'(stable), 64'd5);
`ifdef FRAME_SEQUENCER_STATS_EN
        chk("stall_missCount", 64'(missCount), 64'd1);
`endif
        ptReady = 1'b1;
        cycles(15);
        chk("stall_rdAddr_after", 64'(rdAddr), 64'd2);
        chk("stall_points", 64'(acc_cnt), 64'd1);

        // Empty frame header, then follow next pointer to 8.
        do_reset();
        init_mem();
        mem[0] = mk_hdr(0, 0, 8);
        mem[8] = mk_hdr(0, 2, 8);
        enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycles(1);
            if (rdAddr == 13'd8) found = 1'b1;
        end
        chk("empty_next_addr8", 64'(found), 64'd1);
        cycles(6);
        chk("empty_flag", 64'(emptyFrame), 64'd1);
        chk("empty_no_edge", 64'(edge_cnt), 64'd0);
        exp_q.push_back(9);
        pulse_step();
        cycles(10);
        chk("empty_queue_left", 64'(exp_q.size()), 64'd0);
        enable = 1'b0;
        cycles(3);
        chk("empty_retained", 64'(emptyFrame), 64'd1);

        // Address wrap with a self-looping header at the top of memory.
        do_reset();
        init_mem();
        mem[8191] = mk_hdr(0, 1, 8191);
        startAddr = 13'd8191;
        enable = 1'b1;
        cycles(10);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(0);
            pulse_step();
            cycles(12);
        end
        chk("wrap_points", 64'(acc_cnt), 64'd3);
        chk("wrap_edges", 64'(edge_cnt), 64'd3);
        chk("wrap_queue_left", 64'(exp_q.size()), 64'd0);

        // Enable drop during PT_RD, then reset during PT_OUT.
        do_reset();
        init_mem();
        mem[16] = mk_hdr(0, 3, 16);
        startAddr = 13'd16;
        enable = 1'b1;
        cycles(10);
        chk("abort_hdr_addr", 64'(rdAddr), 64'd17);
        step = 1'b1;
        cycles(1);
        step = 1'b0;
        enable = 1'b0;
        cycles(1);
        chk("abort_ptValid", 64'(ptValid), 64'd0);
        chk("abort_rdAddr", 64'(rdAddr), 64'd16);
        stable = 0;
        for (int c = 0; c < 4; c++) begin
            cycles(1);
            if (ptValid) stable++;
        end
        chk("abort_read_discarded", 64'(stable), 64'd0);
        enable = 1'b1;
        cycles(10);
        ptReady = 1'b0;
        pulse_step();
        wait_valid("abort_valid_timeout");
        chk("abort_point_held", 64'({ptColor, ptX, ptY, ptZ}), 64'(mk_pt(13'd17)));
        reset = 1'b1;
        #1;
        chk("areset_rdAddr", 64'(rdAddr), 64'd0);
        chk("areset_ptValid", 64'(ptValid), 64'd0);
        chk("areset_fields", 64'({ptColor, ptX, ptY, ptZ}), 64'd0);
        chk("areset_frameEdge", 64'(frameEdge), 64'd0);
        chk("areset_emptyFrame", 64'(emptyFrame), 64'd0);
        cycles(2);
        reset = 1'b0;
        enable = 1'b0;
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
